count_checker: RTL
==================

# count_checker

Sequence checker that sits directly downstream of the multi-mode counter and watches its `count` output. It taps the counter's control inputs and predicts each next `count` value for binary, gray, ring and johnson modes. It flags any deviation, holds sticky status and counts the errors. The checker is used in simulation and in silicon debug to catch counter corruption, glitches or control misrouting.

## Interface
- `COUNT_WIDTH`, default 4: width of the watched count; minimum 2.
- `ERR_CNT_WIDTH`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1: clock, shared with the counter.
- `reset`  in  1: synchronous, active-high reset (the clock is `clk`).
- `count_in`  in  COUNT_WIDTH: counter `count` output.
- `count_dir`  in  1: counter direction tap; 1 = up, 0 = down.
- `count_enable_`  in  1: counter enable tap, active-low.
- `count_type`  in  2: counter type tap; 0 = binary, 1 = gray, 2 = ring, 3 = johnson.
- `load_`  in  1: counter load tap, active-low.
- `load_val`  in  COUNT_WIDTH: counter load value tap.
- `err_clr`  in  1: synchronous clear of the error status, active-high.
- `err_pulse`  out  1: one-cycle pulse for each mismatch.
- `err_sticky`  out  1: set by any error, held until `err_clr` or `reset`.
- `err_cnt`  out  ERR_CNT_WIDTH: saturating count of errors.
- `err_expected`  out  COUNT_WIDTH: predicted value at the first error since the last clear.
- `err_actual`  out  COUNT_WIDTH: observed value at the first error since the last clear.
- `legal_err`  out  1: illegal-pattern pulse; see Configuration.

## Operation
- Internal state:
  - `armed` flag.
  - `expect_q` [COUNT_WIDTH]: predicted next count.
  - `type_q` [2]: mirror of the counter's latched type.
- Prediction, evaluated every cycle from `count_in` and the taps:
  - `load_`=0 → expected = `load_val`; `type_q` takes `count_type`.
  - else `count_enable_`=1 → expected = `count_in`.
  - else by `type_q`:
    - binary: `count_in` ±1, modulo 2^COUNT_WIDTH.
    - gray: gray→bin, ±1 modulo 2^W, then bin→gray.
    - ring: up = {in[0], in[W-1:1]}; down = {in[W-2:0], in[W-1]}.
    - johnson: up = {~in[0], in[W-1:1]}; down = {in[W-2:0], ~in[W-1]}.
- `load_` has priority over `count_enable_`.
- `type_q` changes only on load, exactly as in the counter.
- On each edge with `armed`=1: mismatch = (`count_in` != `expect_q`). The new prediction is loaded into `expect_q` on every edge.
- On a mismatch:
  - `err_pulse`=1 for the next cycle.
  - `err_sticky`=1.
  - `err_cnt` increments, saturating at all-ones.
  - If `err_sticky` was 0: `err_expected`/`err_actual` capture `expect_q`/`count_in`.
- After a mismatch, prediction continues from the observed `count_in` (resynchronises). There is no cascade of errors.
- `armed` is 0 after reset and sets on the first edge. The first sample is never compared.

## Timing
- Reset values:
  - `err_pulse`=0, `err_sticky`=0, `err_cnt`=0.
  - `err_expected`=0, `err_actual`=0, `legal_err`=0.
  - `armed`=0, `type_q`=0 (binary), `expect_q`=0.
- Latency: if edge k+1 samples a wrong `count_in`, `err_pulse` is high from edge k+1 to edge k+2. The taps sampled at edge k govern the value checked at edge k+1.
- Wrap-around: binary up 4'hF→4'h0, binary down 0→F and gray wrap are legal. They are not errors.
- `err_clr` together with a new mismatch on the same edge: the clear applies first, then the new error is recorded. Result: `err_cnt`=1, sticky=1, capture = new values.
- `err_clr` alone: sticky, count and captures return to 0. `err_pulse` is unaffected.
- `reset` mid-operation returns everything to reset values on the next edge and disarms the checker. The counter's own reset is not observed: after a counter reset, the checker is reset too.

## Configuration
- `COUNT_CHECKER_LEGAL_EN` defined: on each armed edge, `count_in` is also checked for pattern legality.
  - ring (`type_q`=2): `count_in` must be one-hot.
  - johnson (`type_q`=3): the vector must have at most one bit transition between adjacent positions, non-circular.
  - A violation pulses `legal_err` for one cycle. It also sets `err_sticky` but does not increment `err_cnt`.
- Not defined: no legality logic; `legal_err` is tied to 0.

## Test plan
- Binary up, W=4, load 4'hE, enable 4 cycles: observed E, F, 0, 1 → `err_pulse` never asserts and `err_cnt`=0.
- Gray down after loading 4'b0000, 3 steps: 0000, 1000, 1001, 1011 → no error. Forcing `count_in`=1111 instead of 1001 → `err_pulse` 1 cycle later, `err_expected`=1001, `err_actual`=1111, `err_cnt`=1.
- Ring up from a load of 4'b0001: expect 1000, 0100. Inject 0110 → one error, then resync: the next expected value is 0011, no second error.
- Johnson down from 0000: 0001, 0011, 0111, 1111, 1110. With `COUNT_CHECKER_LEGAL_EN`, injecting 0101 → `legal_err` and `err_pulse` both pulse, and `err_cnt`=1.
- Force 300 consecutive mismatches → `err_cnt` saturates at 8'hFF. `err_clr` on the same edge as a mismatch → `err_cnt`=1, sticky=1.
- Assert `reset` mid-stream with `err_sticky`=1 → all outputs 0. The first post-reset sample is not compared, even if it is inconsistent.

Source files
------------

// File: rtl/count_checker_if.sv
// Tap/status bundle between a multi-mode counter's control taps and its sequence checker.
// Latency: none, wires only.
// Backpressure: none; every tap is sampled on every clock edge.
interface count_checker_if #(
    parameter int COUNT_WIDTH   = 4,
    parameter int ERR_CNT_WIDTH = 8
);
    logic [COUNT_WIDTH-1:0]   count_in;
    logic                     count_dir;
    logic                     count_enable_;
    logic [1:0]               count_type;
    logic                     load_;
    logic [COUNT_WIDTH-1:0]   load_val;
    logic                     err_clr;
    logic                     err_pulse;
    logic                     err_sticky;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;
    logic [COUNT_WIDTH-1:0]   err_expected;
    logic [COUNT_WIDTH-1:0]   err_actual;
    logic                     legal_err;

    // Side that drives the counter taps and observes the checker status.
    modport master (
        output count_in, count_dir, count_enable_, count_type, load_, load_val, err_clr,
        input  err_pulse, err_sticky, err_cnt, err_expected, err_actual, legal_err
    );

    // The checker itself.
    modport slave (
        input  count_in, count_dir, count_enable_, count_type, load_, load_val, err_clr,
        output err_pulse, err_sticky, err_cnt, err_expected, err_actual, legal_err
    );
endinterface

// File: rtl/count_checker.sv
// Predicts the next value of a binary/gray/ring/johnson counter from its taps and flags deviations.
// Latency: a wrong sample at edge k+1 shows on err_pulse from edge k+1 to k+2; status registered.
// Backpressure: none; one sample per clock. Optional pattern legality check via COUNT_CHECKER_LEGAL_EN.
module count_checker #(
    parameter int COUNT_WIDTH   = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    count_checker_if.slave bus
);
    localparam int W = COUNT_WIDTH;

    localparam logic [1:0] TYPE_BIN     = 2'd0;
    localparam logic [1:0] TYPE_GRAY    = 2'd1;
    localparam logic [1:0] TYPE_RING    = 2'd2;
    localparam logic [1:0] TYPE_JOHNSON = 2'd3;

    localparam logic [W-1:0]             ONE_W   = W'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] ONE_E   = ERR_CNT_WIDTH'(1);
    localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                     armed;
    logic [W-1:0]             expect_q;
    logic [1:0]               type_q;
    logic                     pulse_q;
    logic                     legal_q;
    logic                     sticky_q;
    logic [ERR_CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]             exp_cap_q;
    logic [W-1:0]             act_cap_q;

    logic [W-1:0]             bin_cur;
    logic [W-1:0]             bin_step;
    logic [W-1:0]             pred;
    logic                     mismatch;
    logic                     illegal;
    logic                     sticky_base;
    logic [ERR_CNT_WIDTH-1:0] cnt_base;
    logic                     sticky_n;
    logic [ERR_CNT_WIDTH-1:0] cnt_n;
    logic [W-1:0]             exp_cap_n;
    logic [W-1:0]             act_cap_n;

    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Next-count prediction from the current sample, the taps and the latched counter type.
    always_comb begin
        bin_cur  = gray_to_bin(bus.count_in);
        bin_step = bus.count_dir ? bin_cur + ONE_W : bin_cur - ONE_W;
        pred     = bus.count_in;
        if (!bus.load_) begin
            pred = bus.load_val;
        end else if (!bus.count_enable_) begin
            case (type_q)
                TYPE_BIN:     pred = bus.count_dir ? bus.count_in + ONE_W : bus.count_in - ONE_W;
                TYPE_GRAY:    pred = bin_step ^ (bin_step >> 1);
                TYPE_RING:    pred = bus.count_dir ? {bus.count_in[0], bus.count_in[W-1:1]}
                                                   : {bus.count_in[W-2:0], bus.count_in[W-1]};
                TYPE_JOHNSON: pred = bus.count_dir ? {~bus.count_in[0], bus.count_in[W-1:1]}
                                                   : {bus.count_in[W-2:0], ~bus.count_in[W-1]};
                default:      pred = bus.count_in;
            endcase
        end
    end

    assign mismatch = armed && (bus.count_in != expect_q);

`ifdef COUNT_CHECKER_LEGAL_EN
    logic [W-1:0] in_m1;
    logic [W-1:0] trans;
    logic [W-1:0] trans_m1;
    logic         one_hot;
    logic         johnson_ok;

    // Pattern legality: ring must be one-hot, johnson has at most one adjacent-bit transition.
    always_comb begin
        in_m1      = bus.count_in - ONE_W;
        one_hot    = (bus.count_in != '0) && ((bus.count_in & in_m1) == '0);
        trans      = (bus.count_in ^ (bus.count_in >> 1)) & {1'b0, {(W-1){1'b1}}};
        trans_m1   = trans - ONE_W;
        johnson_ok = (trans & trans_m1) == '0;
        illegal    = armed && (((type_q == TYPE_RING) && !one_hot) ||
                               ((type_q == TYPE_JOHNSON) && !johnson_ok));
    end
`else
    assign illegal = 1'b0;
`endif

    // Error status next-state: a clear on the same edge is applied before the new error is recorded.
    always_comb begin
        sticky_base = bus.err_clr ? 1'b0 : sticky_q;
        cnt_base    = bus.err_clr ? '0 : cnt_q;
        exp_cap_n   = bus.err_clr ? '0 : exp_cap_q;
        act_cap_n   = bus.err_clr ? '0 : act_cap_q;
        cnt_n       = cnt_base;
        if (mismatch) begin
            if (cnt_base != CNT_MAX) begin
                cnt_n = cnt_base + ONE_E;
            end
            if (!sticky_base) begin
                exp_cap_n = expect_q;
                act_cap_n = bus.count_in;
            end
        end
        sticky_n = sticky_base || mismatch || illegal;
    end

    // State and status registers; prediction always reloads so a mismatch resynchronises.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed     <= 1'b0;
            expect_q  <= '0;
            type_q    <= TYPE_BIN;
            pulse_q   <= 1'b0;
            legal_q   <= 1'b0;
            sticky_q  <= 1'b0;
            cnt_q     <= '0;
            exp_cap_q <= '0;
            act_cap_q <= '0;
        end else begin
            armed     <= 1'b1;
            expect_q  <= pred;
            if (!bus.load_) begin
                type_q <= bus.count_type;
            end
            pulse_q   <= mismatch;
            legal_q   <= illegal;
            sticky_q  <= sticky_n;
            cnt_q     <= cnt_n;
            exp_cap_q <= exp_cap_n;
            act_cap_q <= act_cap_n;
        end
    end

    assign bus.err_pulse    = pulse_q;
    assign bus.err_sticky   = sticky_q;
    assign bus.err_cnt      = cnt_q;
    assign bus.err_expected = exp_cap_q;
    assign bus.err_actual   = act_cap_q;
    assign bus.legal_err    = legal_q;
endmodule
